// File: rtl/pkt_out_framer.sv
// pkt_out_framer: final stage of the packet-control path.
// Splits 36-bit capture-memory words into two 18-bit pad beats, prefixes each
// packet with a header beat and separates packets with a programmable idle gap.
// ADC_DATA/ADC_DATA_VALID are registered: the beat decided in cycle t is on the
// pads in cycle t+1. in_ready is combinational and only high in DATA_HI.
module pkt_out_framer #(
  parameter int unsigned IN_W    = 36,      // memory word width, equals 2*OUT_W
  parameter int unsigned OUT_W   = 18,      // pad data width
  parameter logic [7:0]  HDR_TAG = 8'hA5    // fixed tag carried in header [15:8]
) (
  input  logic              pktctrl_clk,
  input  logic              pktctrl_rst,
  input  logic              rf_capture_start,
  input  logic              rf_capture_again,
  input  logic [1:0]        rf_pkt_data_length,
  input  logic [15:0]       rf_pkt_idle_length,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [OUT_W-1:0]  ADC_DATA,
  output logic              ADC_DATA_VALID,
  output logic              capture_done,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Packet length code to words per packet: 0=64, 1=128, 2=256, 3=512.
  function automatic logic [9:0] decode_len(input logic [1:0] code);
    return 10'd64 << code;
  endfunction

  // Saturating increment for the underflow counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state_q, state_d;
  logic [OUT_W-1:0]  adc_data_q, adc_data_d;
  logic              adc_vld_q, adc_vld_d;
  logic              capture_done_q, capture_done_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic [7:0]        seq_q, seq_d;
  logic [9:0]        len_words_q, len_words_d;
  logic [9:0]        word_cnt_q, word_cnt_d;
  logic [15:0]       idle_len_q, idle_len_d;
  logic [15:0]       gap_cnt_q, gap_cnt_d;
  logic              last_q, last_d;
  logic              again_q;
  logic [OUT_W-1:0]  lo_q;

  logic              again_rise;
  logic              pkt_full;
  logic [OUT_W-1:0]  hdr_beat;

  assign in_ready   = (state_q == S_DATA_HI);
  assign again_rise = rf_capture_again & ~again_q;
  // word_cnt_q counts LO beats already sent; this LO beat completes the packet.
  assign pkt_full   = ((word_cnt_q + 10'd1) == len_words_q);
  assign hdr_beat   = {2'b10, HDR_TAG, seq_q};

  assign ADC_DATA       = adc_data_q;
  assign ADC_DATA_VALID = adc_vld_q;
  assign capture_done   = capture_done_q;
  assign pkt_cnt        = pkt_cnt_q;
  assign stall_cnt      = stall_cnt_q;

  // Next-state and next-output decision; an undecided cycle drives an idle bus.
  always_comb begin
    state_d        = state_q;
    adc_data_d     = '0;
    adc_vld_d      = 1'b0;
    capture_done_d = capture_done_q;
    pkt_cnt_d      = pkt_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    seq_d          = seq_q;
    len_words_d    = len_words_q;
    word_cnt_d     = word_cnt_q;
    idle_len_d     = idle_len_q;
    gap_cnt_d      = gap_cnt_q;
    last_d         = last_q;

    case (state_q)
      S_IDLE: begin
        seq_d = 8'd0;
        if (rf_capture_start) begin
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        // Configuration is sampled only here so mid-packet writes wait a packet.
        len_words_d = decode_len(rf_pkt_data_length);
        idle_len_d  = rf_pkt_idle_length;
        adc_data_d  = hdr_beat;
        adc_vld_d   = 1'b1;
        word_cnt_d  = 10'd0;
        last_d      = 1'b0;
        state_d     = S_DATA_HI;
      end

      S_DATA_HI: begin
        if (in_valid) begin
          adc_data_d = in_data[IN_W-1:OUT_W];
          adc_vld_d  = 1'b1;
          last_d     = in_last;
          state_d    = S_DATA_LO;
        end else begin
          stall_cnt_d = sat_inc16(stall_cnt_q);
        end
      end

      S_DATA_LO: begin
        adc_data_d = lo_q;
        adc_vld_d  = 1'b1;
        word_cnt_d = word_cnt_q + 10'd1;
        if (last_q || pkt_full) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          seq_d     = seq_q + 8'd1;
          if (last_q) begin
            capture_done_d = 1'b1;
            state_d        = S_DONE;
          end else if (idle_len_q == 16'd0) begin
            // Zero gap: the header follows the last data beat directly.
            state_d = rf_capture_start ? S_HDR : S_IDLE;
          end else begin
            gap_cnt_d = idle_len_q - 16'd1;
            state_d   = S_GAP;
          end
        end else begin
          state_d = S_DATA_HI;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == 16'd0) begin
          state_d = rf_capture_start ? S_HDR : S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end

      S_DONE: begin
        // A restart edge takes priority over a simultaneous drop of start.
        if (again_rise) begin
          seq_d          = 8'd0;
          capture_done_d = 1'b0;
          state_d        = S_HDR;
        end else if (!rf_capture_start) begin
          capture_done_d = 1'b0;
          state_d        = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state, counters and registered pad outputs; async reset clears all.
  always_ff @(posedge pktctrl_clk or posedge pktctrl_rst) begin
    if (pktctrl_rst) begin
      state_q        <= S_IDLE;
      adc_data_q     <= '0;
      adc_vld_q      <= 1'b0;
      capture_done_q <= 1'b0;
      pkt_cnt_q      <= 16'd0;
      stall_cnt_q    <= 16'd0;
      seq_q          <= 8'd0;
      len_words_q    <= 10'd64;
      word_cnt_q     <= 10'd0;
      idle_len_q     <= 16'd0;
      gap_cnt_q      <= 16'd0;
      last_q         <= 1'b0;
      again_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      adc_data_q     <= adc_data_d;
      adc_vld_q      <= adc_vld_d;
      capture_done_q <= capture_done_d;
      pkt_cnt_q      <= pkt_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      seq_q          <= seq_d;
      len_words_q    <= len_words_d;
      word_cnt_q     <= word_cnt_d;
      idle_len_q     <= idle_len_d;
      gap_cnt_q      <= gap_cnt_d;
      last_q         <= last_d;
      again_q        <= rf_capture_again;
    end
  end

  // Low half of the accepted word, held for the following DATA_LO beat.
  always_ff @(posedge pktctrl_clk) begin
    if (in_ready && in_valid) begin
      lo_q <= in_data[OUT_W-1:0];
    end
  end

endmodule
